// File: rtl/psg_pkg.sv
// Shared constants and helpers for the multi-unit SN76489-style PSG.
package psg_pkg;

  localparam logic [15:0] LFSR_SEED        = 16'h8000;
  localparam logic [7:0]  STEREO_RESET     = 8'hFF;
  localparam logic [9:0]  NOISE_RATE_16    = 10'd16;
  localparam logic [9:0]  NOISE_RATE_32    = 10'd32;
  localparam logic [9:0]  NOISE_RATE_64    = 10'd64;
  localparam logic [2:0]  LATCH_NOISE_CTRL = 3'd6;

  localparam logic [9:0] VOL [16] = '{
    10'd1023, 10'd813, 10'd646, 10'd513, 10'd407, 10'd323, 10'd257, 10'd205,
    10'd162,  10'd128, 10'd102, 10'd81,  10'd64,  10'd51,  10'd40,  10'd0
  };

  typedef enum logic [1:0] {
    TGT_TONE,
    TGT_ATTEN,
    TGT_NOISE
  } tgt_e;

  function automatic tgt_e latch_target(input logic [2:0] latch);
    if (latch[0])                     return TGT_ATTEN;
    else if (latch == LATCH_NOISE_CTRL) return TGT_NOISE;
    else                              return TGT_TONE;
  endfunction

  function automatic logic [9:0] vol(input logic [3:0] atten);
    return VOL[atten];
  endfunction

endpackage

// File: rtl/psg_unit.sv
// One PSG unit: command registers, three tone counters, noise LFSR and
// per-channel output levels.
module psg_unit
  import psg_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_tick,
  input  logic            i_wren,
  input  logic [7:0]      i_wrdata,
  output logic [3:0][9:0] o_level
);

  logic [2:0]       r_latch;
  logic [2:0][9:0]  r_period;
  logic [3:0][3:0]  r_atten;
  logic [2:0]       r_ctrl;
  logic [2:0][9:0]  r_cnt;
  logic [9:0]       r_ncnt;
  logic [3:0]       r_val;
  logic [15:0]      r_lfsr;

  logic [2:0]  w_latch;
  logic [1:0]  w_ch;
  logic [9:0]  w_nrate;
  logic        w_fb;
  logic [15:0] w_lfsr_next;

  // A latch byte retargets the write before its low nibble is applied.
  assign w_latch     = i_wrdata[7] ? i_wrdata[6:4] : r_latch;
  assign w_ch        = w_latch[2:1];
  assign w_fb        = r_ctrl[2] ? (r_lfsr[0] ^ r_lfsr[3]) : r_lfsr[0];
  assign w_lfsr_next = {w_fb, r_lfsr[15:1]};

  always_comb begin
    case (r_ctrl[1:0])
      2'd0:    w_nrate = NOISE_RATE_16;
      2'd1:    w_nrate = NOISE_RATE_32;
      2'd2:    w_nrate = NOISE_RATE_64;
      default: w_nrate = r_period[2];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_latch  <= '0;
      r_period <= '0;
      r_atten  <= '1;
      r_ctrl   <= '0;
      r_cnt    <= '0;
      r_ncnt   <= '0;
      r_val    <= '0;
      r_lfsr   <= LFSR_SEED;
    end else begin
      if (i_tick) begin
        for (int unsigned c = 0; c < 3; c++) begin
          if (r_cnt[c] <= 10'd1) begin
            r_cnt[c] <= r_period[c];
            r_val[c] <= (r_period[c] <= 10'd1) ? 1'b1 : ~r_val[c];
          end else begin
            r_cnt[c] <= r_cnt[c] - 10'd1;
          end
        end
        if (r_ncnt <= 10'd1) begin
          r_ncnt   <= w_nrate;
          r_lfsr   <= w_lfsr_next;
          r_val[3] <= w_lfsr_next[0];
        end else begin
          r_ncnt <= r_ncnt - 10'd1;
        end
      end
      // Written after the tick so a noise-ctrl reseed overrides a same-cycle shift.
      if (i_wren) begin
        if (i_wrdata[7]) r_latch <= i_wrdata[6:4];
        case (latch_target(w_latch))
          TGT_ATTEN: r_atten[w_ch] <= i_wrdata[3:0];
          TGT_NOISE: begin
            r_ctrl <= i_wrdata[2:0];
            r_lfsr <= LFSR_SEED;
          end
          default: begin
            if (i_wrdata[7]) r_period[w_ch][3:0] <= i_wrdata[3:0];
            else             r_period[w_ch][9:4] <= i_wrdata[5:0];
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < 4; c++) begin
      o_level[c] = r_val[c] ? vol(r_atten[c]) : '0;
    end
  end

endmodule

// File: rtl/psg_multi.sv
// NUM_PSG independent PSG units with per-channel stereo enables, mixed to a
// 16-bit unsigned L/R pair whose full scale is independent of NUM_PSG.
module psg_multi
  import psg_pkg::*;
#(
  parameter  int unsigned NUM_PSG = 1,
  parameter  int unsigned CLK_DIV = 256,
  localparam int unsigned SEL_W   = (NUM_PSG > 1) ? $clog2(NUM_PSG) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] wrsel,
  input  logic [7:0]       wrdata,
  input  logic             wren,
  input  logic             stereo_wren,
  output logic [15:0]      sample_l,
  output logic [15:0]      sample_r,
  output logic             sample_strobe
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned SHIFT = 4 - $clog2(NUM_PSG);

  logic [DIV_W-1:0]             r_div;
  logic                         r_tick_d;
  logic [NUM_PSG-1:0][7:0]      r_stereo;
  logic [15:0]                  r_sample_l;
  logic [15:0]                  r_sample_r;
  logic                         r_strobe;
  logic                         w_tick;
  logic [NUM_PSG-1:0]           w_unit_we;
  logic [NUM_PSG-1:0][3:0][9:0] w_level;
  logic [15:0]                  w_sum_l;
  logic [15:0]                  w_sum_r;

  assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

  for (genvar u = 0; u < NUM_PSG; u++) begin : g_unit
    assign w_unit_we[u] = wren && (wrsel == SEL_W'(u));
    psg_unit u_unit (
      .clk      (clk),
      .reset    (reset),
      .i_tick   (w_tick),
      .i_wren   (w_unit_we[u]),
      .i_wrdata (wrdata),
      .o_level  (w_level[u])
    );
  end

  always_comb begin
    w_sum_l = '0;
    w_sum_r = '0;
    for (int unsigned u = 0; u < NUM_PSG; u++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (r_stereo[u][4+c]) w_sum_l = w_sum_l + 16'(w_level[u][c]);
        if (r_stereo[u][c])   w_sum_r = w_sum_r + 16'(w_level[u][c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div      <= '0;
      r_tick_d   <= 1'b0;
      r_stereo   <= {NUM_PSG{STEREO_RESET}};
      r_sample_l <= '0;
      r_sample_r <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_div    <= w_tick ? '0 : r_div + 1'b1;
      r_tick_d <= w_tick;
      r_strobe <= r_tick_d;
      if (r_tick_d) begin
        r_sample_l <= w_sum_l << SHIFT;
        r_sample_r <= w_sum_r << SHIFT;
      end
      if (stereo_wren) begin
        for (int unsigned u = 0; u < NUM_PSG; u++) begin
          if (wrsel == SEL_W'(u)) r_stereo[u] <= wrdata;
        end
      end
    end
  end

  assign sample_l      = r_sample_l;
  assign sample_r      = r_sample_r;
  assign sample_strobe = r_strobe;

endmodule

// File: tb/tb_psg_multi.sv
// Bench for psg_multi with two units: a tick-level reference model queues the
// expected mix per tick, a monitor checks it on every strobe.
module tb_psg_multi;

  localparam int unsigned NP = 2;
  localparam int unsigned CD = 4;

  localparam int VOLT [16] = '{1023, 813, 646, 513, 407, 323, 257, 205,
                               162, 128, 102, 81, 64, 51, 40, 0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [0:0]  wrsel = '0;
  logic [7:0]  wrdata = '0;
  logic        wren = 1'b0;
  logic        stereo_wren = 1'b0;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_strobe;

  psg_multi #(.NUM_PSG(NP), .CLK_DIV(CD)) dut (
    .clk           (clk),
    .reset         (reset),
    .wrsel         (wrsel),
    .wrdata        (wrdata),
    .wren          (wren),
    .stereo_wren   (stereo_wren),
    .sample_l      (sample_l),
    .sample_r      (sample_r),
    .sample_strobe (sample_strobe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_strobes = 0;

  typedef struct { int l; int r; } exp_t;
  exp_t q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model state, one entry per unit / channel (channel 3 = noise).
  int m_div;
  int m_latch  [NP];
  int m_period [NP][3];
  int m_atten  [NP][4];
  int m_ctrl   [NP];
  int m_cnt    [NP][4];
  bit m_val    [NP][4];
  int m_lfsr   [NP];
  int m_st     [NP];

  task automatic model_reset();
    m_div = 0;
    for (int u = 0; u < NP; u++) begin
      m_latch[u] = 0;
      m_ctrl[u]  = 0;
      m_lfsr[u]  = 'h8000;
      m_st[u]    = 'hFF;
      for (int c = 0; c < 4; c++) begin
        m_atten[u][c] = 15;
        m_cnt[u][c]   = 0;
        m_val[u][c]   = 0;
        if (c < 3) m_period[u][c] = 0;
      end
    end
  endtask

  task automatic model_tick(input int u);
    int rate;
    int fb;
    for (int c = 0; c < 3; c++) begin
      if (m_cnt[u][c] <= 1) begin
        m_cnt[u][c] = m_period[u][c];
        m_val[u][c] = (m_period[u][c] < 2) ? 1'b1 : !m_val[u][c];
      end else begin
        m_cnt[u][c] = m_cnt[u][c] - 1;
      end
    end
    rate = (m_ctrl[u] % 4 == 3) ? m_period[u][2] : (16 << (m_ctrl[u] % 4));
    if (m_cnt[u][3] <= 1) begin
      m_cnt[u][3] = rate;
      fb = m_lfsr[u] % 2;
      if (m_ctrl[u] >= 4) fb = (fb + (m_lfsr[u] / 8)) % 2;
      m_lfsr[u] = m_lfsr[u] / 2 + fb * 32768;
      m_val[u][3] = (m_lfsr[u] % 2) == 1;
    end else begin
      m_cnt[u][3] = m_cnt[u][3] - 1;
    end
  endtask

  task automatic model_write(input int u, input int d);
    int ch;
    if (d >= 128) m_latch[u] = (d / 16) % 8;
    ch = m_latch[u] / 2;
    if (m_latch[u] % 2 == 1) m_atten[u][ch] = d % 16;
    else if (ch == 3) begin
      m_ctrl[u] = d % 8;
      m_lfsr[u] = 'h8000;
    end else if (d >= 128) m_period[u][ch] = (m_period[u][ch] / 16) * 16 + d % 16;
    else m_period[u][ch] = m_period[u][ch] % 16 + (d % 64) * 16;
  endtask

  function automatic exp_t model_mix();
    exp_t e;
    int sl = 0;
    int sr = 0;
    for (int u = 0; u < NP; u++) begin
      for (int c = 0; c < 4; c++) begin
        int lvl;
        lvl = m_val[u][c] ? VOLT[m_atten[u][c]] : 0;
        if ((m_st[u] >> (4 + c)) % 2 == 1) sl += lvl;
        if ((m_st[u] >> c) % 2 == 1)       sr += lvl;
      end
    end
    e.l = sl * 16 / NP;
    e.r = sr * 16 / NP;
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      model_reset();
      q.delete();
    end else begin
      bit t;
      t = (m_div == CD - 1);
      m_div = t ? 0 : m_div + 1;
      if (t) for (int u = 0; u < NP; u++) model_tick(u);
      if (wren) model_write(int'(wrsel), int'(wrdata));
      if (stereo_wren) m_st[wrsel] = int'(wrdata);
      if (t) q.push_back(model_mix());
    end
  end

  always @(negedge clk) begin
    if (sample_strobe) begin
      n_strobes++;
      if (q.size() == 0) check("spurious_strobe", int'(q.size()), 1);
      else begin
        exp_t e;
        e = q.pop_front();
        check("sb_sample_l", int'(sample_l), e.l);
        check("sb_sample_r", int'(sample_r), e.r);
      end
    end
  end

  task automatic wr(input int sel, input int d);
    @(negedge clk);
    wrsel = 1'(sel); wrdata = 8'(d); wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic wr_st(input int sel, input int d);
    @(negedge clk);
    wrsel = 1'(sel); wrdata = 8'(d); stereo_wren = 1'b1;
    @(negedge clk);
    stereo_wren = 1'b0;
  endtask

  task automatic wr_both(input int sel, input int d);
    @(negedge clk);
    wrsel = 1'(sel); wrdata = 8'(d); wren = 1'b1; stereo_wren = 1'b1;
    @(negedge clk);
    wren = 1'b0; stereo_wren = 1'b0;
  endtask

  task automatic wait_strobes(input int n);
    for (int k = 0; k < n; k++) begin
      int i;
      i = 0;
      do begin
        @(negedge clk);
        i++;
      end while (!sample_strobe && i < 4 * CD);
      if (!sample_strobe) check("strobe_timeout", int'(sample_strobe), 1);
    end
  endtask

  task automatic expect_mix(input string name, input int l, input int r);
    wait_strobes(2);
    check({name, "_l"}, int'(sample_l), l);
    check({name, "_r"}, int'(sample_r), r);
  endtask

  initial begin
    int gap;
    repeat (3) @(negedge clk);
    check("reset_sample_l", int'(sample_l), 0);
    check("reset_sample_r", int'(sample_r), 0);
    check("reset_strobe", int'(sample_strobe), 0);
    reset = 1'b0;

    wait_strobes(1);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!sample_strobe && gap < 4 * CD);
    check("strobe_period", gap, CD);

    wr(0, 'h90); wr(1, 'h90);
    expect_mix("dc_both_units", 16368, 16368);
    wr(1, 'h9F);
    expect_mix("dc_unit0_only", 8184, 8184);
    wr_st(0, 'h0F);
    expect_mix("stereo_right_only", 0, 8184);
    wr_both(1, 'h90);
    expect_mix("wren_and_stereo", 8184, 8184);
    wr_st(0, 'hFF); wr_st(1, 'hFF);
    expect_mix("stereo_restored", 16368, 16368);

    wr(0, 'h85); wr(0, 'h00);
    repeat (25 * CD) @(negedge clk);
    wr(0, 'h01);
    repeat (100 * CD) @(negedge clk);

    wr(0, 'h9F); wr(1, 'h9F);
    wr(0, 'hE4); wr(0, 'hF0);
    repeat (16 * 17 * CD) @(negedge clk);
    wr(0, 'hE4);
    repeat (16 * 6 * CD) @(negedge clk);
    wr(0, 'hFF);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_sample_l", int'(sample_l), 0);
    check("midreset_sample_r", int'(sample_r), 0);
    check("midreset_strobe", int'(sample_strobe), 0);
    reset = 1'b0;
    expect_mix("post_reset_silent", 0, 0);
    wr(0, 'h90);
    expect_mix("post_reset_dc", 8184, 8184);
    wr(1, 'hB0); wr(1, 'h07);
    expect_mix("atten_data_byte", 9824, 9824);

    repeat (3000) begin
      @(negedge clk);
      wren        = ($urandom_range(0, 3) == 0);
      stereo_wren = ($urandom_range(0, 15) == 0);
      wrsel       = 1'($urandom_range(0, 1));
      wrdata      = 8'($urandom);
    end
    @(negedge clk);
    wren = 1'b0; stereo_wren = 1'b0;
    repeat (3 * CD) @(negedge clk);

    check("strobes_seen", int'(n_strobes >= 1000), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psg_multi.md
# psg_multi

Parametrised successor to the single SN76489-style PSG. Instantiates NUM_PSG independent PSG units, each with 3 tone channels and 1 noise channel, adds per-channel Game Gear–style stereo enables, and mixes everything into a 16-bit unsigned left/right pair. The output is scaled so full scale is the same for every legal NUM_PSG. It sits on the sound bus in place of the single PSG and feeds the audio DAC/mixer.

## Interface
- NUM_PSG, 1: number of PSG units. Legal values: 1, 2, 4.
- CLK_DIV, 256: clk cycles per PSG tick. Must be ≥2.
- SEL_W, derived: max(1, log2(NUM_PSG)).
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wrsel  in  SEL_W  PSG unit targeted by wren/stereo_wren
- wrdata  in  8  command/data byte
- wren  in  1  write wrdata to unit wrsel's tone/noise registers
- stereo_wren  in  1  write wrdata to unit wrsel's stereo register
- sample_l  out  16  left mix, unsigned; reset 0
- sample_r  out  16  right mix, unsigned; reset 0
- sample_strobe  out  1  one-cycle pulse when samples update; reset 0

## Operation
- Write decode, per unit:
  - Byte with bit7=1: latch[2:0] <= wrdata[6:4], then write wrdata[3:0] to the latched target.
  - Latched target is tone period (even latch, ch<3): period[3:0].
  - Latched target is attenuation (odd latch): atten.
  - Latched target is noise control (latch=6): ctrl[2:0] <= wrdata[2:0] and LFSR <= 0x8000.
- Byte with bit7=0, by latched type:
  - Tone period: period[9:4] <= wrdata[5:0].
  - Attenuation: atten <= wrdata[3:0].
  - Noise control: ctrl <= wrdata[2:0] and LFSR reset.
- A write with wrsel ≥ NUM_PSG is ignored.
- Stereo register: bit(4+n) enables channel n on the left, bit n enables it on the right; n=3 is noise. Reset value 0xFF.
- Tone channel behaviour on each tick:
  - If cnt ≤ 1: cnt <= period and val toggles.
  - Otherwise cnt decrements.
  - The half-period is therefore `period` ticks.
  - period 0 or 1: val is forced to 1 (DC), and the counter still reloads.
- Noise rate select, ctrl[1:0]: 00 → 16, 01 → 32, 10 → 64, 11 → the same unit's tone-3 period.
- Noise channel: same counter rule as the tone channels. On each expiry:
  - LFSR <= {fb, LFSR[15:1]}, where fb = ctrl[2] ? (LFSR[0]^LFSR[3]) : LFSR[0].
  - val <= new LFSR[0].
- Level per channel: val ? VOL[atten] : 0. VOL = 1023, 813, 646, 513, 407, 323, 257, 205, 162, 128, 102, 81, 64, 51, 40, 0.
- Mix: sum_l = Σ level over channels with the left enable set (same for right).
- Scaling: sample = sum << (4 − log2 NUM_PSG). Maximum is 65472, so no saturation is needed.
- Reset values:
  - period 0, atten 0xF, ctrl 0, latch 0, cnt 0, val 0.
  - LFSR 0x8000, stereo 0xFF, divider 0.

## Timing
- Divider counts 0..CLK_DIV−1; tick is asserted when divider = CLK_DIV−1.
- Counters, val, and the LFSR update only on tick.
- sample_l, sample_r and sample_strobe register on the cycle after tick and reflect post-tick channel state. Strobe period = CLK_DIV.
- A register write at cycle t is visible from t+1; it affects the audio from the first tick after t.
- Write in the same cycle as tick: the tick uses old register values.
- LFSR reset (noise-ctrl write) in the same cycle as a noise expiry: the reset wins, giving LFSR = 0x8000.
- wren and stereo_wren asserted together: both applied.
- Reset asserted mid-operation: every state element, including the divider and outputs, returns to its reset value on that edge.

## Structure
- Package psg_pkg holds:
  - VOL table
  - latch/type encodings
  - LFSR seed 0x8000
  - noise rate constants 16/32/64
  - stereo reset value 0xFF
- Sub-module psg_unit: one unit's registers, 3 tone counters, noise/LFSR, and 4 level outputs.
- The top level owns:
  - the shared divider/tick
  - wrsel decode
  - stereo registers
  - the L/R adder tree, shift, and output registers

## Test plan
- Reset, NUM_PSG=1, CLK_DIV=4: outputs 0, strobe every 4 cycles. Write 0x90 (tone 1 atten 0, period 0) → sample_l = sample_r = 16368 from the first strobe after the write.
- Write 0x85 then 0x00 (period 5), 0x90 → sample toggles between 16368 and 0 every 5 ticks. Then write 0x01 → half-period 21 ticks.
- Write 0xE4 (white, rate 16), 0xF0 → noise level 0 for the first 14 expiries (every 16 ticks), 1023 (sample 16368) on the 15th. Rewrite 0xE4 mid-sequence → the sequence restarts.
- Attenuation via data byte: 0xB0, then 0x07 → tone 2 level 205 (sample 3280).
- Stereo: with tone 1 at 1023, stereo_wren 0x0F → sample_l = 0, sample_r = 16368. 0xFF restores both.
- NUM_PSG=2: tone 1 DC atten 0 on both units → sample 16368. Write to unit 1 only → 8184. Assert reset for one cycle mid-tone → all outputs 0 and registers at reset values.
